// File: rtl/fft_stage_controller.sv
// rtl/fft_stage_controller.sv - in-place radix-2 DIT FFT stage sequencer and address generator
module fft_stage_controller #(
  parameter int LOG2N      = 4,
  parameter int RD_LATENCY = 1,
  parameter int BF_LATENCY = 9,
  localparam int L         = RD_LATENCY + BF_LATENCY,
  localparam int SW        = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int KW = LOG2N - 1;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [SW-1:0] S_LAST   = SW'(LOG2N - 1);
  localparam logic [KW-1:0] K_LAST   = '1;
  localparam logic [CW-1:0] CNT_INIT = CW'(L - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             busy_q, done_q, rd_en_q;
  logic [SW-1:0]    stage_q;
  logic [LOG2N-1:0] rd_a_q, rd_b_q;
  logic [LOG2N-2:0] tw_q;

  // write-back delay line: valid bits plus the two destination addresses
  logic [L-1:0]     pv_q;
  logic [LOG2N-1:0] pa_q [L];
  logic [LOG2N-1:0] pb_q [L];

  logic [LOG2N-1:0] span, mask, k_ext, pos, addr_a, addr_b;
  logic [LOG2N-2:0] tw_next;
  logic [SW-1:0]    tw_shift;
  logic             issue_next, busy_next;

  // state and loop counters
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state: issue N/2 butterflies, drain L cycles, repeat per stage, then FIN
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          s_d     = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          cnt_d   = CNT_INIT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          if (s_q == S_LAST) begin
            state_d = FIN;
          end else begin
            state_d = ISSUE;
            s_d     = s_q + 1'b1;
            k_d     = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // butterfly addresses for the upcoming (k_d, s_d): insert a zero bit at position s
  always_comb begin
    span       = {{(LOG2N-1){1'b0}}, 1'b1} << s_d;
    mask       = span - 1'b1;
    k_ext      = {1'b0, k_d};
    pos        = k_ext & mask;
    addr_a     = ((k_ext & ~mask) << 1) | pos;
    addr_b     = addr_a | span;
    tw_shift   = S_LAST - s_d;
    tw_next    = pos[LOG2N-2:0] << tw_shift;
    issue_next = (state_d == ISSUE);
    busy_next  = (state_d == ISSUE) || (state_d == DRAIN);
  end

  // registered outputs and write-back delay line
  always_ff @(posedge clk) begin
    if (clr) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stage_q <= '0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      pv_q    <= '0;
      for (int i = 0; i < L; i++) begin
        pa_q[i] <= '0;
        pb_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_next;
      done_q  <= (state_d == FIN);
      stage_q <= busy_next ? s_d : '0;
      rd_en_q <= issue_next;
      rd_a_q  <= issue_next ? addr_a : '0;
      rd_b_q  <= issue_next ? addr_b : '0;
      tw_q    <= issue_next ? tw_next : '0;
      pv_q    <= {pv_q[L-2:0], rd_en_q};
      pa_q[0] <= rd_a_q;
      pb_q[0] <= rd_b_q;
      for (int i = 1; i < L; i++) begin
        pa_q[i] <= pa_q[i-1];
        pb_q[i] <= pb_q[i-1];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = stage_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_addr   = tw_q;
  assign wr_en     = pv_q[L-1];
  assign wr_addr_a = pa_q[L-1];
  assign wr_addr_b = pb_q[L-1];

endmodule

// File: tb/tb_fft_stage_controller.sv
// tb/tb_fft_stage_controller.sv - directed self-checking bench for fft_stage_controller
module tb_fft_stage_controller;

  localparam int LOG2N = 4;
  localparam int N     = 16;
  localparam int H     = 8;
  localparam int LAT   = 10;
  localparam int PER   = H + LAT;
  localparam real PI   = 3.14159265358979;

  logic       clk = 1'b0;
  logic       clr, start;
  logic       busy, done, rd_en, wr_en;
  logic [1:0] stage;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_addr;

  int passes = 0;
  int checks = 0;
  logic load = 1'b0;

  always #5 clk = ~clk;

  fft_stage_controller #(.LOG2N(LOG2N), .RD_LATENCY(1), .BF_LATENCY(9)) dut (
    .clk(clk), .clr(clr), .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  // memory + ideal butterfly + twiddle model driven by the controller's addresses
  real mre[N], mim[N], ire[N], iim[N];
  real qar[LAT], qai[LAT], qbr[LAT], qbi[LAT];
  real wc, ws, tr, ti;

  always_comb begin
    wc = $cos(2.0 * PI * real'(int'(tw_addr)) / real'(N));
    ws = $sin(2.0 * PI * real'(int'(tw_addr)) / real'(N));
    tr = mre[rd_addr_b] * wc + mim[rd_addr_b] * ws;
    ti = mim[rd_addr_b] * wc - mre[rd_addr_b] * ws;
  end

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) begin
        mre[i] <= ire[i];
        mim[i] <= iim[i];
      end
    end else if (wr_en) begin
      mre[wr_addr_a] <= qar[LAT-1];
      mim[wr_addr_a] <= qai[LAT-1];
      mre[wr_addr_b] <= qbr[LAT-1];
      mim[wr_addr_b] <= qbi[LAT-1];
    end
    qar[0] <= mre[rd_addr_a] + tr;
    qai[0] <= mim[rd_addr_a] + ti;
    qbr[0] <= mre[rd_addr_a] - tr;
    qbi[0] <= mim[rd_addr_a] - ti;
    for (int i = 1; i < LAT; i++) begin
      qar[i] <= qar[i-1];
      qai[i] <= qai[i-1];
      qbr[i] <= qbr[i-1];
      qbi[i] <= qbi[i-1];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_near(input string tag, input real obs, input real exp);
    checks++;
    assert (obs - exp <= 2.0 && exp - obs <= 2.0) passes++;
    else $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
  endtask

  // expected read for cycle c after start: {valid, a, b, tw}, all zero when idle
  function automatic logic [11:0] iss(input int c);
    int s, off, span, pos, grp, a, b, tw;
    if (c < 1 || c > LOG2N * PER) return 12'h0;
    s   = (c - 1) / PER;
    off = (c - 1) % PER;
    if (off >= H) return 12'h0;
    span = 1 << s;
    pos  = off % span;
    grp  = off / span;
    a    = grp * 2 * span + pos;
    b    = a + span;
    tw   = pos << (LOG2N - 1 - s);
    return {1'b1, 4'(a), 4'(b), 3'(tw)};
  endfunction

  function automatic logic [24:0] expect_at(input int c);
    logic [11:0] r, w;
    logic        bz;
    int          s;
    r  = iss(c);
    w  = iss(c - LAT);
    bz = (c >= 1 && c <= LOG2N * PER);
    s  = bz ? (c - 1) / PER : 0;
    return {bz, c == LOG2N * PER + 1, 2'(s), r[11], r[10:0], w[11:3]};
  endfunction

  function automatic logic [24:0] observe();
    return {busy, done, stage, rd_en,
            rd_en ? {rd_addr_a, rd_addr_b, tw_addr} : 11'h0,
            wr_en, wr_en ? {wr_addr_a, wr_addr_b} : 8'h0};
  endfunction

  function automatic int bitrev(input int n);
    logic [3:0] v;
    v = 4'(n);
    return int'({v[0], v[1], v[2], v[3]});
  endfunction

  // entered at the negedge of cycle 0 with start already high
  task automatic run(input int abort_c, input bit pulses, input int last_c,
                     input bit restart, input bit tally);
    int cnt[4][16];
    logic [24:0] e;
    for (int s = 0; s < 4; s++) for (int a = 0; a < 16; a++) cnt[s][a] = 0;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      start = 1'b0;
      clr   = 1'b0;
      e = (abort_c > 0 && c > abort_c) ? 25'h0 : expect_at(c);
      check($sformatf("cyc%0d", c), 32'(observe()), 32'(e));
      if (tally) begin
        if (c == 1)  check("s0k0_addr", {rd_addr_a, rd_addr_b, tw_addr}, {4'd0, 4'd1, 3'd0});
        if (c == 2)  check("s0k1_addr", {rd_addr_a, rd_addr_b, tw_addr}, {4'd2, 4'd3, 3'd0});
        if (c == 20) check("s1k1_addr", {rd_addr_a, rd_addr_b, tw_addr}, {4'd1, 4'd3, 3'd4});
        if (c == 60) check("s3k5_addr", {rd_addr_a, rd_addr_b, tw_addr}, {4'd5, 4'd13, 3'd5});
        if (c == 10) check("no_wr_c10", 32'(wr_en), 32'd0);
        if (c == 11) check("first_wr", {wr_en, wr_addr_a, wr_addr_b}, {1'b1, 4'd0, 4'd1});
        if (c == 19) check("s1_first_rd", {rd_en, stage}, {1'b1, 2'd1});
        if (c == 73) check("done_busy_73", {done, busy}, 2'b10);
        if (rd_en) begin
          cnt[stage][rd_addr_a]++;
          cnt[stage][rd_addr_b]++;
        end
      end
      if (c == abort_c) clr = 1'b1;
      if (pulses && (c == 30 || c == 73)) start = 1'b1;
      if (restart && c == last_c) start = 1'b1;
    end
    if (tally)
      for (int s = 0; s < 4; s++)
        for (int a = 0; a < 16; a++)
          check($sformatf("reads_s%0d_a%0d", s, a), 32'(cnt[s][a]), 32'd1);
  endtask

  initial begin
    clr   = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_raw", {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
                        wr_en, wr_addr_a, wr_addr_b}, 32'h0);
    clr   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d", i), 32'(observe()), 32'h0);
    end

    // transform with ignored starts at cycle 30 and in FIN, then back-to-back start
    start = 1'b1;
    run(0, 1'b1, 74, 1'b1, 1'b1);
    // abort at cycle 25, restart at cycle 30
    run(25, 1'b0, 30, 1'b1, 1'b0);
    // fresh transform after the abort, runs into IDLE
    run(0, 1'b0, 76, 1'b0, 1'b1);

    // impulse at index 0
    for (int i = 0; i < N; i++) begin
      ire[i] = (i == 0) ? 100.0 : 0.0;
      iim[i] = 0.0;
    end
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b1;
    run(0, 1'b0, 74, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) begin
      check_near($sformatf("imp_re%0d", k), mre[k], 100.0);
      check_near($sformatf("imp_im%0d", k), mim[k], 0.0);
    end

    // complex tone at bin 3, stored in bit-reversed order
    for (int n = 0; n < N; n++) begin
      ire[bitrev(n)] = 100.0 * $cos(2.0 * PI * 3.0 * real'(n) / real'(N));
      iim[bitrev(n)] = 100.0 * $sin(2.0 * PI * 3.0 * real'(n) / real'(N));
    end
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b1;
    run(0, 1'b0, 74, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) begin
      check_near($sformatf("tone_re%0d", k), mre[k], (k == 3) ? 1600.0 : 0.0);
      check_near($sformatf("tone_im%0d", k), mim[k], 0.0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
